fpcdiv_iterative: RTL
=====================

Name: fpcdiv_iterative

Overview:
- Fixed-point iterative complex divider: computes c = a / b on signed complex operands. It is the inverse-direction companion of the team's complex multiplier.
- Computation: c = a·conj(b) / |b|².
- Resources: one internal shift-add multiplier time-shared over six products, then one restoring divider used twice.
- Sits beside the complex multiplier in the DSP datapath and uses the same val/rdy latency-insensitive interface.

Parameters:
- n, 32, total bit width, signed two's complement
- d, 16, number of fractional bits (requires 0 < d < n)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk)
- recv_val  in  1  input operands valid
- recv_rdy  out  1  block ready to accept operands
- ar, ac  in  n  real and imaginary parts of dividend a
- br, bc  in  n  real and imaginary parts of divisor b
- send_val  out  1  result valid
- send_rdy  in  1  consumer ready
- cr, cc  out  n  real and imaginary parts of quotient c
- err  out  1  divide-by-zero flag, valid while send_val=1

Behaviour:
- Reset (reset==0 at posedge), overriding everything including mid-operation:
  - state=IDLE, recv_rdy=1, send_val=0, cr=cc=0, err=0.
  - Any in-flight computation is discarded.
- States: IDLE -> MUL -> DIV -> DONE -> IDLE.
- IDLE:
  - recv_rdy=1, send_val=0.
  - On recv_val&recv_rdy, register ar/ac/br/bc and go to MUL.
- MUL (6n cycles):
  - Six signed products, n cycles each, in this order: ar·br, ac·bc, ac·br, ar·bc, br·br, bc·bc.
  - Each product: full 2n-bit signed result, keep bits [n+d-1:d] (truncate, no rounding, wrap on overflow).
  - Form three values, each wrapping mod 2^n:
    - nr = ar·br + ac·bc
    - ni = ac·br − ar·bc
    - den = br·br + bc·bc
- DIV (2(n+d) cycles):
  - Restoring division on magnitudes: q = (|num| << d) / |den|, n+d iterations, real first, then imaginary.
  - Quotient sign = sign(num) XOR sign(den). Truncate toward zero.
  - Saturation: if |q| > 2^(n-1)−1, output 2^(n-1)−1 for a positive result and −2^(n-1) for a negative one.
  - den==0: skip the divides, set cr=cc=0 and err=1. Total latency is unchanged (the cycle count is padded).
- DONE:
  - send_val=1. cr/cc/err stay stable until the handshake.
  - On send_val&send_rdy, go to IDLE next cycle with send_val=0 and recv_rdy=1.
- Latency: send_val rises exactly L = 6n + 2(n+d) + 2 cycles after the accepting edge. For the defaults, L = 290.
- Handshake rules:
  - recv_rdy=0 in MUL, DIV and DONE. No new input is accepted in the same cycle a result is sent (minimum 1 idle cycle between jobs).
  - recv_val asserted outside IDLE is ignored. Inputs need not be held after acceptance.
  - send_rdy may be held low indefinitely: the block stalls in DONE with outputs frozen.
  - send_rdy asserted before send_val has no effect.
- cr/cc/err update only on entry to DONE and hold their values through IDLE until the next result.

Test Plan:
- Basic divide (defaults n=32, d=16):
  - Stimulus: a=3+4i (ar=0x00030000, ac=0x00040000), b=1+2i (0x00010000, 0x00020000).
  - Required: after exactly 290 cycles, cr=0x00023333 (2.2), cc=0xFFFF999A (−0.4), err=0.
- Identity divisor:
  - Stimulus: a=1.5−2.25i (0x00018000, 0xFFFDC000), b=1+0i.
  - Required: cr=0x00018000, cc=0xFFFDC000, err=0.
- Divide by zero:
  - Stimulus: a=5+5i, b=0+0i.
  - Required: send_val at cycle 290, cr=cc=0, err=1.
- Saturation:
  - Stimulus: a=30000+0i (0x75300000), b=0.5 (0x00008000).
  - Required: cr=0x7FFFFFFF; with a=−30000, cr=0x80000000; cc=0 in both cases.
- Backpressure and back-to-back:
  - Stimulus: hold send_rdy=0 for 20 cycles after send_val, with recv_val=1 throughout.
  - Required: outputs stable, recv_rdy=0 the whole time. After the send handshake, recv_rdy=1 the next cycle and the second job's result arrives 290 cycles after its acceptance.
- Mid-operation reset:
  - Stimulus: assert reset=0 for 1 cycle at cycle 100 of a job.
  - Required: next cycle recv_rdy=1, send_val=0, cr=cc=err=0. A new job then completes correctly with no stale result emitted.

Source files
------------

// File: rtl/fpcdiv_iterative.sv
// Fixed-point iterative complex divider: c = a * conj(b) / |b|^2 on signed Qn.d operands.
// Latency: result valid exactly 6n + 2(n+d) + 2 cycles after the accepting edge (290 for n=32, d=16).
// Backpressure: single job in flight; recv_rdy low until the result is taken; stalls in DONE while send_rdy=0.
// Ports:
//   clk, reset (sync, active-low)
//   recv_val/recv_rdy + ar, ac, br, bc : operand handshake (a = ar + j*ac, b = br + j*bc)
//   send_val/send_rdy + cr, cc, err    : result handshake (err flags divide by zero)
module fpcdiv_iterative #(
  parameter int n = 32,
  parameter int d = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] ar,
  input  logic [n-1:0] ac,
  input  logic [n-1:0] br,
  input  logic [n-1:0] bc,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] cr,
  output logic [n-1:0] cc,
  output logic         err
);
  localparam int QW = n + d;
  localparam int BW = (n > 1) ? $clog2(n) : 1;
  localparam int SW = $clog2(QW + 1);
  localparam logic [QW-1:0] MAXQ = {{(d+1){1'b0}}, {(n-1){1'b1}}};
  localparam logic [n-1:0]  MAXV = {1'b0, {(n-1){1'b1}}};
  localparam logic [n-1:0]  MINV = {1'b1, {(n-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state_q;
  logic [n-1:0]    ar_q, ac_q, br_q, bc_q;
  logic [BW-1:0]   bit_q;
  logic [2:0]      prod_q;
  logic [2*n-1:0]  acc_q, mc_q;
  logic [n-1:0]    mp_q;
  logic [n-1:0]    nr_q, ni_q, den_q;
  logic            half_q;
  logic [SW-1:0]   step_q;
  logic [n-1:0]    rem_q, dvs_q;
  logic [QW-1:0]   quo_q;
  logic [n-1:0]    qr_q;
  logic            recv_rdy_q, send_val_q, err_q;
  logic [n-1:0]    cr_q, cc_q;

  logic [n-1:0]    mc_sel, mp_sel, mp_cur, prod_t;
  logic [2*n-1:0]  mc_cur, acc_cur, acc_d;
  logic [n-1:0]    num_sel, num_mag, den_mag, rem_sub, rem_d, q_sat;
  logic [n:0]      rem_sh;
  logic            ge, neg;
  logic [QW-1:0]   quo_d;

  // Shift-add multiplier step. Product order: ar*br, ac*bc, ac*br, ar*bc, br*br, bc*bc,
  // so the multiplier operand simply alternates br/bc.
  always_comb begin
    case (prod_q)
      3'd1, 3'd2: mc_sel = ac_q;
      3'd4:       mc_sel = br_q;
      3'd5:       mc_sel = bc_q;
      default:    mc_sel = ar_q;
    endcase
    mp_sel  = prod_q[0] ? bc_q : br_q;
    // First bit of each product loads fresh operands instead of the shifted registers.
    mc_cur  = (bit_q == '0) ? {{n{mc_sel[n-1]}}, mc_sel} : mc_q;
    mp_cur  = (bit_q == '0) ? mp_sel : mp_q;
    acc_cur = (bit_q == '0) ? '0 : acc_q;
    // The multiplier MSB carries weight -2^(n-1): subtract instead of add.
    if (!mp_cur[0])                 acc_d = acc_cur;
    else if (bit_q == BW'(n - 1))   acc_d = acc_cur - mc_cur;
    else                            acc_d = acc_cur + mc_cur;
    prod_t = acc_d[n+d-1:d];
  end

  // Restoring divider step on magnitudes, plus sign/saturation of the finished quotient.
  always_comb begin
    num_sel = half_q ? ni_q : nr_q;
    num_mag = num_sel[n-1] ? -num_sel : num_sel;
    den_mag = den_q[n-1] ? -den_q : den_q;
    rem_sh  = {rem_q, quo_q[QW-1]};
    ge      = (rem_sh >= {1'b0, dvs_q});
    // When ge holds the difference is below the divisor, so n bits suffice.
    rem_sub = rem_sh[n-1:0] - dvs_q;
    rem_d   = ge ? rem_sub : rem_sh[n-1:0];
    quo_d   = {quo_q[QW-2:0], ge};
    neg     = num_sel[n-1] ^ den_q[n-1];
    if (quo_d > MAXQ) q_sat = neg ? MINV : MAXV;
    else              q_sat = neg ? -quo_d[n-1:0] : quo_d[n-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      recv_rdy_q <= 1'b1;
      send_val_q <= 1'b0;
      cr_q       <= '0;
      cc_q       <= '0;
      err_q      <= 1'b0;
      bit_q      <= '0;
      prod_q     <= '0;
      step_q     <= '0;
      half_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (recv_val && recv_rdy_q) begin
            ar_q       <= ar;
            ac_q       <= ac;
            br_q       <= br;
            bc_q       <= bc;
            bit_q      <= '0;
            prod_q     <= '0;
            recv_rdy_q <= 1'b0;
            state_q    <= MUL;
          end
        end
        MUL: begin
          acc_q <= acc_d;
          mc_q  <= mc_cur << 1;
          mp_q  <= mp_cur >> 1;
          if (bit_q == BW'(n - 1)) begin
            bit_q <= '0;
            case (prod_q)
              3'd0:    nr_q  <= prod_t;
              3'd1:    nr_q  <= nr_q + prod_t;
              3'd2:    ni_q  <= prod_t;
              3'd3:    ni_q  <= ni_q - prod_t;
              3'd4:    den_q <= prod_t;
              default: den_q <= den_q + prod_t;
            endcase
            if (prod_q == 3'd5) begin
              prod_q  <= '0;
              half_q  <= 1'b0;
              step_q  <= '0;
              state_q <= DIV;
            end else begin
              prod_q <= prod_q + 3'd1;
            end
          end else begin
            bit_q <= bit_q + BW'(1);
          end
        end
        DIV: begin
          // Each half: one setup cycle then n+d iterations. A zero divisor still runs
          // the full schedule so latency stays fixed; its result is replaced below.
          if (step_q == '0) begin
            rem_q  <= '0;
            quo_q  <= {num_mag, {d{1'b0}}};
            dvs_q  <= den_mag;
            step_q <= SW'(1);
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (step_q == SW'(QW)) begin
              step_q <= '0;
              if (!half_q) begin
                qr_q   <= q_sat;
                half_q <= 1'b1;
              end else begin
                state_q    <= DONE;
                send_val_q <= 1'b1;
                if (den_q == '0) begin
                  cr_q  <= '0;
                  cc_q  <= '0;
                  err_q <= 1'b1;
                end else begin
                  cr_q  <= qr_q;
                  cc_q  <= q_sat;
                  err_q <= 1'b0;
                end
              end
            end else begin
              step_q <= step_q + SW'(1);
            end
          end
        end
        DONE: begin
          if (send_rdy) begin
            send_val_q <= 1'b0;
            recv_rdy_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign recv_rdy = recv_rdy_q;
  assign send_val = send_val_q;
  assign cr       = cr_q;
  assign cc       = cc_q;
  assign err      = err_q;
endmodule
